// File: rtl/data_mem_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// timer control bit positions and default base addresses.
package data_mem_pkg;

  // Byte offsets of the registers inside the 64-byte I/O page
  localparam logic [5:0] LED_OFS      = 6'h00;
  localparam logic [5:0] DIP_OFS      = 6'h04;
  localparam logic [5:0] SEVENSEG_OFS = 6'h08;
  localparam logic [5:0] CYCLE_OFS    = 6'h0C;
  localparam logic [5:0] TLOAD_OFS    = 6'h10;
  localparam logic [5:0] TCTRL_OFS    = 6'h14;
  localparam logic [5:0] TCOUNT_OFS   = 6'h18;

  // Bit positions inside TCTRL
  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;
  localparam int EXP_BIT  = 8;

  // Default memory map
  localparam logic [31:0] DEFAULT_RAM_BASE  = 32'h0000_0800;
  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-port bus between the core's Memory stage and the responder.
interface data_mem_responder_if;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  // Core side drives address/data/strobe and samples read data
  modport master (output MemWrite, output Addr, output WriteData, input ReadData);
  // Responder side
  modport slave  (input MemWrite, input Addr, input WriteData, output ReadData);
endinterface

// File: rtl/mmio_timer.sv
// Down-counting timer with load/count registers, EN/AUTO control and a
// sticky expired flag (write-1-clear). Expiry has priority over the clear.
module mmio_timer
  import data_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load_we,
  input  logic        i_ctrl_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_ctrl,
  output logic        o_irq
);

  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_en;
  logic        r_auto;
  logic        r_exp;
  logic        w_expire;
  logic [31:0] w_ctrl;

  // The timer expires on an enabled cycle that starts with count == 0
  assign w_expire = r_en && (r_count == 32'd0);

  // Timer state update: TLOAD write beats countdown/reload, TCTRL write beats auto-disable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load  <= 32'd0;
      r_count <= 32'd0;
      r_en    <= 1'b0;
      r_auto  <= 1'b0;
      r_exp   <= 1'b0;
    end else begin
      if (i_load_we) begin
        r_load  <= i_wdata;
        r_count <= i_wdata;
      end else if (w_expire) begin
        r_load  <= r_load;
        r_count <= r_auto ? r_load : r_count;
      end else if (r_en) begin
        r_load  <= r_load;
        r_count <= r_count - 32'd1;
      end else begin
        r_load  <= r_load;
        r_count <= r_count;
      end

      if (i_ctrl_we) begin
        r_en   <= i_wdata[EN_BIT];
        r_auto <= i_wdata[AUTO_BIT];
      end else if (w_expire && !r_auto) begin
        r_en   <= 1'b0;
        r_auto <= r_auto;
      end else begin
        r_en   <= r_en;
        r_auto <= r_auto;
      end

      if (w_expire) begin
        r_exp <= 1'b1;
      end else if (i_ctrl_we && i_wdata[EXP_BIT]) begin
        r_exp <= 1'b0;
      end else begin
        r_exp <= r_exp;
      end
    end
  end

  // Assemble the TCTRL readback word
  always_comb begin
    w_ctrl           = 32'd0;
    w_ctrl[EN_BIT]   = r_en;
    w_ctrl[AUTO_BIT] = r_auto;
    w_ctrl[EXP_BIT]  = r_exp;
  end

  assign o_count = r_count;
  assign o_ctrl  = w_ctrl;
  assign o_irq   = r_exp;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: word-addressed data RAM
// plus a 64-byte I/O page (LEDs, switches, seven-segment, cycle counter, timer).
// Reads are combinational; writes commit on the rising edge.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] RAM_BASE  = DEFAULT_RAM_BASE,
  parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
  input  logic                       CLK,
  input  logic                       Reset,
  data_mem_responder_if.slave        bus,
  input  logic [15:0]                DIP,
  output logic [15:0]                LED,
  output logic [31:0]                SevenSeg,
  output logic                       TimerIrq,
  output logic                       AccessFault
);

  localparam int          IDX_W   = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'(RAM_WORDS) * 33'd4);

  logic [31:0]      r_ram [RAM_WORDS];
  logic [15:0]      r_led;
  logic [31:0]      r_seg;
  logic [31:0]      r_cycle;
  logic [15:0]      r_dip_s1;
  logic [15:0]      r_dip_s2;
  logic             r_fault;

  logic             w_ram_hit;
  logic             w_mmio_hit;
  logic [31:0]      w_ram_ofs;
  logic [IDX_W-1:0] w_ram_idx;
  logic [5:0]       w_ofs;
  logic             w_mmio_we;
  logic [31:0]      w_rdata;
  logic [31:0]      w_tcount;
  logic [31:0]      w_tctrl;
  logic             w_irq;

  // Address decode; the two low address bits never select anything
  assign w_ram_hit  = ({1'b0, bus.Addr} >= {1'b0, RAM_BASE}) && ({1'b0, bus.Addr} < RAM_END);
  assign w_mmio_hit = (bus.Addr[31:6] == MMIO_BASE[31:6]);
  assign w_ram_ofs  = bus.Addr - RAM_BASE;
  assign w_ram_idx  = IDX_W'(w_ram_ofs >> 2);
  assign w_ofs      = {bus.Addr[5:2], 2'b00};
  assign w_mmio_we  = bus.MemWrite && w_mmio_hit;

  // Data RAM: synchronous write, contents deliberately not reset
  always_ff @(posedge CLK) begin
    if (bus.MemWrite && w_ram_hit) begin
      r_ram[w_ram_idx] <= bus.WriteData;
    end
  end

  // I/O registers, cycle counter, switch synchronizer and sticky fault flag
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_led    <= 16'd0;
      r_seg    <= 32'd0;
      r_cycle  <= 32'd0;
      r_dip_s1 <= 16'd0;
      r_dip_s2 <= 16'd0;
      r_fault  <= 1'b0;
    end else begin
      r_cycle  <= r_cycle + 32'd1;
      r_dip_s1 <= DIP;
      r_dip_s2 <= r_dip_s1;
      r_led    <= (w_mmio_we && (w_ofs == LED_OFS)) ? bus.WriteData[15:0] : r_led;
      r_seg    <= (w_mmio_we && (w_ofs == SEVENSEG_OFS)) ? bus.WriteData : r_seg;
      r_fault  <= r_fault || (!w_ram_hit && !w_mmio_hit);
    end
  end

  mmio_timer u_timer (
    .i_clk     (CLK),
    .i_rst_n   (Reset),
    .i_load_we (w_mmio_we && (w_ofs == TLOAD_OFS)),
    .i_ctrl_we (w_mmio_we && (w_ofs == TCTRL_OFS)),
    .i_wdata   (bus.WriteData),
    .o_count   (w_tcount),
    .o_ctrl    (w_tctrl),
    .o_irq     (w_irq)
  );

  // Read mux: RAM, I/O page, or zero for unmapped/unused locations
  always_comb begin
    w_rdata = 32'd0;
    if (w_ram_hit) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_mmio_hit) begin
      case (w_ofs)
        LED_OFS:      w_rdata = {16'd0, r_led};
        DIP_OFS:      w_rdata = {16'd0, r_dip_s2};
        SEVENSEG_OFS: w_rdata = r_seg;
        CYCLE_OFS:    w_rdata = r_cycle;
        TLOAD_OFS:    w_rdata = u_timer.r_load;
        TCTRL_OFS:    w_rdata = w_tctrl;
        TCOUNT_OFS:   w_rdata = w_tcount;
        default:      w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign bus.ReadData = w_rdata;
  assign LED          = r_led;
  assign SevenSeg     = r_seg;
  assign TimerIrq     = w_irq;
  assign AccessFault  = r_fault;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

  localparam logic [31:0] MB     = 32'hFFFF_0000;
  localparam logic [31:0] A_LED  = MB + 32'h00;
  localparam logic [31:0] A_DIP  = MB + 32'h04;
  localparam logic [31:0] A_SEG  = MB + 32'h08;
  localparam logic [31:0] A_CYC  = MB + 32'h0C;
  localparam logic [31:0] A_TLD  = MB + 32'h10;
  localparam logic [31:0] A_TCT  = MB + 32'h14;
  localparam logic [31:0] A_TCN  = MB + 32'h18;

  logic        CLK;
  logic        Reset;
  logic [15:0] DIP;
  logic [15:0] LED;
  logic [31:0] SevenSeg;
  logic        TimerIrq;
  logic        AccessFault;

  int n_checks;
  int n_errors;

  data_mem_responder_if bus ();

  data_mem_responder dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .bus         (bus),
    .DIP         (DIP),
    .LED         (LED),
    .SevenSeg    (SevenSeg),
    .TimerIrq    (TimerIrq),
    .AccessFault (AccessFault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr      = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    bus.MemWrite = 1'b0;
    bus.Addr     = a;
    #1;
    check_eq(tag, bus.ReadData, exp_v);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    Reset         = 1'b0;
    DIP           = 16'h0000;
    bus.MemWrite  = 1'b0;
    bus.Addr      = 32'h0000_0800;
    bus.WriteData = 32'd0;
    #2;
    check_eq("rst_led", {16'd0, LED}, 32'd0);
    check_eq("rst_seg", SevenSeg, 32'd0);
    check_eq("rst_irq", {31'd0, TimerIrq}, 32'd0);
    check_eq("rst_fault", {31'd0, AccessFault}, 32'd0);
    #11;
    Reset = 1'b1;
    tick();

    // RAM: same-cycle read sees old data, next cycle sees new
    wr(32'h0000_0804, 32'h1111_1111);
    bus.Addr      = 32'h0000_0804;
    bus.WriteData = 32'hDEAD_BEEF;
    bus.MemWrite  = 1'b1;
    #1;
    check_eq("ram_old", bus.ReadData, 32'h1111_1111);
    tick();
    bus.MemWrite = 1'b0;
    rd_chk("ram_new", 32'h0000_0804, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h0000_0807, 32'hDEAD_BEEF);
    wr(32'h0000_0BFC, 32'hA5A5_0001);
    rd_chk("ram_last", 32'h0000_0BFC, 32'hA5A5_0001);
    rd_chk("ram_other", 32'h0000_0804, 32'hDEAD_BEEF);

    // MMIO registers
    wr(A_LED, 32'h1234_ABCD);
    rd_chk("led_rd", A_LED, 32'h0000_ABCD);
    check_eq("led_port", {16'd0, LED}, 32'h0000_ABCD);
    wr(A_SEG, 32'hCAFE_F00D);
    rd_chk("seg_rd", A_SEG, 32'hCAFE_F00D);
    check_eq("seg_port", SevenSeg, 32'hCAFE_F00D);
    wr(A_DIP, 32'h0000_FFFF);
    rd_chk("dip_ro", A_DIP, 32'h0000_0000);
    wr(MB + 32'h20, 32'hFFFF_FFFF);
    rd_chk("ofs_unused", MB + 32'h20, 32'h0000_0000);
    check_eq("no_fault", {31'd0, AccessFault}, 32'd0);

    // Timer one-shot: load 3 -> counts 3,2,1,0 then expires on the 4th edge
    wr(A_TLD, 32'd3);
    wr(A_TCT, 32'h0000_0001);
    rd_chk("os_cnt3", A_TCN, 32'd3);
    tick();
    rd_chk("os_cnt2", A_TCN, 32'd2);
    tick();
    rd_chk("os_cnt1", A_TCN, 32'd1);
    tick();
    rd_chk("os_cnt0", A_TCN, 32'd0);
    check_eq("os_irq_lo", {31'd0, TimerIrq}, 32'd0);
    tick();
    rd_chk("os_ctrl_exp", A_TCT, 32'h0000_0100);
    check_eq("os_irq_hi", {31'd0, TimerIrq}, 32'd1);
    rd_chk("os_cnt_hold", A_TCN, 32'd0);
    wr(A_TCT, 32'h0000_0100);
    rd_chk("os_clr", A_TCT, 32'h0000_0000);
    check_eq("os_irq_clr", {31'd0, TimerIrq}, 32'd0);

    // Auto-reload with W1C in the expiry cycle
    wr(A_TLD, 32'd1);
    wr(A_TCT, 32'h0000_0003);
    tick();
    rd_chk("ar_cnt0", A_TCN, 32'd0);
    wr(A_TCT, 32'h0000_0103);
    rd_chk("ar_ctrl", A_TCT, 32'h0000_0103);
    rd_chk("ar_reload", A_TCN, 32'd1);
    wr(A_TCT, 32'h0000_0100);
    rd_chk("ar_off", A_TCT, 32'h0000_0000);

    // EN=0 written in the expiry cycle: EN follows the write, EXP still set
    wr(A_TLD, 32'd0);
    wr(A_TCT, 32'h0000_0001);
    wr(A_TCT, 32'h0000_0000);
    rd_chk("en_wr_exp", A_TCT, 32'h0000_0100);
    wr(A_TCT, 32'h0000_0100);

    // Unmapped accesses
    rd_chk("unmap_rd", 32'h0000_0000, 32'h0000_0000);
    tick();
    check_eq("fault_set", {31'd0, AccessFault}, 32'd1);
    rd_chk("unmap_top", 32'h0000_0C00, 32'h0000_0000);
    wr(32'h0000_0C00, 32'h1234_5678);
    rd_chk("unmap_below", 32'h0000_07FC, 32'h0000_0000);
    bus.Addr = 32'h0000_0800;
    tick();
    tick();
    check_eq("fault_sticky", {31'd0, AccessFault}, 32'd1);

    // Reset mid-operation
    DIP   = 16'h5A5A;
    #2;
    Reset = 1'b0;
    #1;
    Reset = 1'b1;
    wr(A_LED, 32'h0000_00FF);
    wr(A_TLD, 32'd200);
    wr(A_TCT, 32'h0000_0001);
    for (int i = 0; i < 32'h54; i++) tick();
    rd_chk("pre_cycle", A_CYC, 32'h0000_0057);
    rd_chk("pre_tcount", A_TCN, 32'd116);
    rd_chk("pre_dip", A_DIP, 32'h0000_5A5A);
    Reset = 1'b0;
    #1;
    check_eq("mid_led", {16'd0, LED}, 32'd0);
    check_eq("mid_seg", SevenSeg, 32'd0);
    check_eq("mid_irq", {31'd0, TimerIrq}, 32'd0);
    check_eq("mid_fault", {31'd0, AccessFault}, 32'd0);
    rd_chk("mid_cycle", A_CYC, 32'd0);
    rd_chk("mid_tcount", A_TCN, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    rd_chk("rel_cycle0", A_CYC, 32'd0);
    tick();
    rd_chk("rel_cycle1", A_CYC, 32'd1);
    rd_chk("rel_dip1", A_DIP, 32'h0000_0000);
    tick();
    rd_chk("rel_dip2", A_DIP, 32'h0000_5A5A);
    rd_chk("rel_tcount", A_TCN, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipelined core's data port. Receives the Memory-stage address, store data and write strobe, and returns read data in the same cycle. Decodes the address into a word-addressed data RAM or a small memory-mapped I/O page: LEDs, switches, seven-segment, a free-running cycle counter and a down-counting timer. Sits outside the core, next to the instruction memory.

## Interface
Parameters:
- RAM_WORDS, 256: data RAM depth in 32-bit words; power of two.
- RAM_BASE, 32'h0000_0800: byte base address of data RAM.
- MMIO_BASE, 32'hFFFF_0000: byte base of the I/O page (64 bytes).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  store strobe from the core's Memory stage.
- Addr  in  32  byte address; Addr[1:0] ignored (word access only).
- WriteData  in  32  store data.
- ReadData  out  32  load data, combinational from Addr and current state.
- DIP  in  16  asynchronous switch inputs.
- LED  out  16  LED register.
- SevenSeg  out  32  seven-segment display register.
- TimerIrq  out  1  equals the timer expired flag.
- AccessFault  out  1  sticky flag for an access to an unmapped address.

## Operation
- RAM hit: RAM_BASE <= Addr < RAM_BASE + 4*RAM_WORDS. Index is Addr[log2(RAM_WORDS)+1:2] relative to RAM_BASE.
- MMIO hit: Addr[31:6] == MMIO_BASE[31:6]. Offsets are as follows.
  - 0x00 LED, RW. Bits [15:0]; upper bits read as 0.
  - 0x04 DIP, RO. Value from a 2-flop synchronizer, zero-extended.
  - 0x08 SEVENSEG, RW, 32 bits.
  - 0x0C CYCLE, RO. 32-bit count, increments every cycle, wraps 0xFFFFFFFF -> 0.
  - 0x10 TLOAD, RW. A write sets both the load and count registers.
  - 0x14 TCTRL. Bit 0 EN (RW). Bit 1 AUTO (RW). Bit 8 EXP (read; write 1 clears).
  - 0x18 TCOUNT, RO.
  - Other offsets in the page read 0; writes to them are ignored (not a fault).
- Unmapped accesses:
  - Read returns 0.
  - Write is dropped.
  - Any access (read or write) sets AccessFault. It is cleared only by reset.
- Writes to RO registers are ignored.
- Timer, evaluated on each cycle with EN=1:
  - If count == 0: set EXP. Then, if AUTO=1, count <= load; otherwise EN <= 0.
  - Otherwise: count <= count - 1.
  - Consequence: load N gives EXP after N+1 enabled cycles.
- Timer precedence rules:
  - A TLOAD write in the same cycle overrides the decrement or reload.
  - An expiry in the same cycle as an EXP write-1-clear wins: EXP stays 1.
  - A TCTRL write of EN=0 in the expiry cycle: the written EN wins, and EXP is still set.

## Timing
- Reads are zero-latency: ReadData is valid combinationally in the same cycle as Addr. The core samples it at the next edge.
- A write commits at the rising edge where MemWrite=1.
  - A read of the same address in that cycle returns the old value.
  - The following cycle returns the new value.
- DIP changes are visible in reads 2 cycles after being stable at the synchronizer input.
- CYCLE reads the value registered before the current edge.
- Reset (asynchronous, Reset=0) clears the following to 0: LED, SevenSeg, CYCLE, load, count, EN, AUTO, EXP, TimerIrq, AccessFault, and both synchronizer stages.
- RAM contents are not reset.
- Reset asserted mid-count aborts the timer immediately. After Reset deasserts, the first rising edge resumes normal operation.

## Structure
- Package data_mem_pkg holds:
  - MMIO offset constants (LED_OFS ... TCOUNT_OFS).
  - TCTRL bit positions (EN_BIT, AUTO_BIT, EXP_BIT).
  - Default base addresses.
- One sub-module, mmio_timer. It holds the load, count, EN/AUTO/EXP state and the precedence logic.
  - Inputs: load-write, ctrl-write, write data.
  - Outputs: count, ctrl readback, irq.
- The top level holds:
  - RAM array (asynchronous read, synchronous write).
  - Address decoder and read mux.
  - LED, SEVENSEG and CYCLE registers.
  - DIP synchronizer.
  - AccessFault flag.

## Test plan
- RAM write/read:
  - Stimulus: write 0xDEADBEEF to 0x0000_0804; in the same cycle read 0x804.
  - Response: the same-cycle read returns the old value; the next cycle returns 0xDEADBEEF.
  - Also: address 0x807 aliases to the same word.
- Timer one-shot:
  - Stimulus: TLOAD=3, then TCTRL=0x1.
  - Response: TCOUNT steps 3,2,1,0. EXP and TimerIrq go to 1 on the 4th enabled edge, and EN reads 0.
  - Then writing TCTRL=0x100 clears EXP.
- Timer auto-reload with collision:
  - Stimulus: TLOAD=1, TCTRL=0x3, and a W1C of EXP issued in the exact expiry cycle.
  - Response: EXP remains 1; count reloads to 1.
- MMIO and fault:
  - Stimulus: write LED=0x1234_ABCD; write SEVENSEG; read 0x0000_0000 (unmapped).
  - Response: LED reads 0x0000_ABCD and the LED port shows it. The unmapped read returns 0 and AccessFault rises, then stays high.
- Reset mid-operation:
  - Stimulus: timer counting and CYCLE=0x57; assert Reset asynchronously between edges.
  - Response: all outputs are 0 immediately. After release, CYCLE restarts from 0 and DIP reads reflect the input after 2 cycles.
